// File: rtl/viol_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : viol_ctrl_pkg
//  Brief    : Shared types and constants for the violation reset controller
//             and its priority encoder.
//  Revision : 1.0  initial release
// ============================================================================
package viol_ctrl_pkg;

    // Controller states; the top re-exports these as fixed-width constants
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HOLD    = 2'd1,
        ST_WAIT_RH = 2'd2
    } viol_state_e;

    localparam logic [15:0] RESET_HANDLER_DEF = 16'hFFFE;
    localparam int          CAUSE_W           = 3;
    localparam int          KILL_CNT_W        = 8;
    localparam int          HOLD_CNT_W        = 8;

    // Saturating increment for the kill counter
    function automatic logic [KILL_CNT_W-1:0] sat_inc(input logic [KILL_CNT_W-1:0] v);
        return (v == {KILL_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/viol_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : viol_prio_enc
//  Brief    : Combinational lowest-index priority encoder. Bit 0 has the
//             highest priority. Also used by the DMA monitor.
//  Revision : 1.0  initial release
// ============================================================================
module viol_prio_enc
    import viol_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [CAUSE_W-1:0] idx,
    output logic               valid
);

    // Scan from the top down so the lowest set index is written last and wins
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = CAUSE_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/violation_reset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : violation_reset_ctrl
//  Brief    : Collects monitor violation pulses, records the first cause,
//             holds the core in reset for a minimum time and releases it
//             only when the CPU fetches from the reset handler with no
//             violation pending.
//             Optional sticky source log enabled by defining VIOL_LOG_EN.
//  Revision : 1.0  initial release
// ============================================================================
module violation_reset_ctrl
    import viol_ctrl_pkg::*;
#(
    parameter int          NUM_SRC       = 4,
    parameter int          MIN_HOLD      = 4,
    parameter logic [15:0] RESET_HANDLER = RESET_HANDLER_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           pc,
    input  logic [NUM_SRC-1:0]    viol_i,
    output logic                  reset_o,
    output logic [CAUSE_W-1:0]    cause_o,
    output logic                  cause_vld_o,
    output logic [KILL_CNT_W-1:0] kill_cnt_o,
    input  logic                  log_clr_i,
    output logic [NUM_SRC-1:0]    log_o
);

    localparam logic [1:0] S_RUN     = ST_RUN;
    localparam logic [1:0] S_HOLD    = ST_HOLD;
    localparam logic [1:0] S_WAIT_RH = ST_WAIT_RH;

    localparam logic [HOLD_CNT_W-1:0] HOLD_RELOAD = HOLD_CNT_W'(MIN_HOLD - 1);

    logic [1:0]            state;
    logic [HOLD_CNT_W-1:0] hold_cnt;
    logic [CAUSE_W-1:0]    first_idx;
    logic                  any_viol;
    logic                  at_handler;

    viol_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .req   (viol_i),
        .idx   (first_idx),
        .valid (any_viol)
    );

    assign at_handler = (pc == RESET_HANDLER);

    // Kill sequencer: enter HOLD on a violation, count down the minimum hold,
    // then wait for a clean fetch from the reset handler before releasing
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RUN;
            reset_o     <= 1'b0;
            cause_o     <= '0;
            cause_vld_o <= 1'b0;
            hold_cnt    <= '0;
            kill_cnt_o  <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (any_viol) begin
                        state      <= S_HOLD;
                        reset_o    <= 1'b1;
                        hold_cnt   <= HOLD_RELOAD;
                        kill_cnt_o <= sat_inc(kill_cnt_o);
                        // Only the first kill since rst records its cause
                        if (!cause_vld_o) begin
                            cause_o     <= first_idx;
                            cause_vld_o <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (any_viol) begin
                        hold_cnt <= HOLD_RELOAD;
                    end else if (hold_cnt == '0) begin
                        state <= S_WAIT_RH;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                S_WAIT_RH: begin
                    // A violation beats a simultaneous release request
                    if (any_viol) begin
                        state    <= S_HOLD;
                        hold_cnt <= HOLD_RELOAD;
                    end else if (at_handler) begin
                        state   <= S_RUN;
                        reset_o <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_RUN;
                    reset_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef VIOL_LOG_EN
    // Sticky per-source log; a set on the same cycle as a clear survives
    always_ff @(posedge clk) begin
        if (rst) begin
            log_o <= '0;
        end else begin
            log_o <= (log_clr_i ? '0 : log_o) | viol_i;
        end
    end
`else
    logic unused_log_clr;
    assign unused_log_clr = log_clr_i;
    assign log_o          = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_violation_reset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_violation_reset_ctrl
//  Brief    : Self-checking bench for violation_reset_ctrl against a
//             quiet-cycle based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_violation_reset_ctrl;

    localparam int          NSRC = 4;
    localparam int          MINH = 4;
    localparam logic [15:0] RH   = 16'hFFFE;

    logic            clk = 1'b0;
    logic            rst;
    logic [15:0]     pc;
    logic [NSRC-1:0] viol_i;
    logic            reset_o;
    logic [2:0]      cause_o;
    logic            cause_vld_o;
    logic [7:0]      kill_cnt_o;
    logic            log_clr_i;
    logic [NSRC-1:0] log_o;

    int n_cmp  = 0;
    int n_mism = 0;

    // Reference model: a kill is active until a clean handler fetch arrives
    // after at least MINH consecutive violation-free cycles
    bit              m_kill;
    int              m_quiet;
    int              m_kills;
    int              m_cause;
    bit              m_cv;
    logic [NSRC-1:0] m_log;

    always #5 clk = ~clk;

    violation_reset_ctrl #(
        .NUM_SRC       (NSRC),
        .MIN_HOLD      (MINH),
        .RESET_HANDLER (RH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .viol_i      (viol_i),
        .reset_o     (reset_o),
        .cause_o     (cause_o),
        .cause_vld_o (cause_vld_o),
        .kill_cnt_o  (kill_cnt_o),
        .log_clr_i   (log_clr_i),
        .log_o       (log_o)
    );

    function automatic int lowest(input logic [NSRC-1:0] v);
        for (int i = 0; i < NSRC; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model(input logic [NSRC-1:0] v, input logic [15:0] p,
                         input logic clr, input logic r);
        if (r) begin
            m_kill = 0; m_quiet = 0; m_kills = 0; m_cause = 0; m_cv = 0; m_log = '0;
        end else begin
            if (!m_kill) begin
                if (v != '0) begin
                    m_kill  = 1;
                    m_quiet = 0;
                    if (m_kills < 255) m_kills++;
                    if (!m_cv) begin m_cause = lowest(v); m_cv = 1; end
                end
            end else if (v != '0) begin
                m_quiet = 0;
            end else if (p == RH && m_quiet >= MINH) begin
                m_kill = 0;
            end else if (m_quiet < 1000) begin
                m_quiet++;
            end
`ifdef VIOL_LOG_EN
            m_log = (clr ? '0 : m_log) | v;
`else
            m_log = '0;
`endif
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mism++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".reset_o"},   32'(reset_o),     32'(m_kill));
        check({tag, ".cause_o"},   32'(cause_o),     32'(m_cause));
        check({tag, ".cause_vld"}, 32'(cause_vld_o), 32'(m_cv));
        check({tag, ".kill_cnt"},  32'(kill_cnt_o),  32'(m_kills));
        check({tag, ".log_o"},     32'(log_o),       32'(m_log));
    endtask

    task automatic step(input string tag, input logic [NSRC-1:0] v, input logic [15:0] p,
                        input logic clr, input logic r);
        viol_i = v; pc = p; log_clr_i = clr; rst = r;
        @(posedge clk);
        model(v, p, clr, r);
        #1;
        check_all(tag);
    endtask

    initial begin
        int hi;
        viol_i = '0; pc = '0; log_clr_i = 1'b0; rst = 1'b1;
        m_kill = 0; m_quiet = 0; m_kills = 0; m_cause = 0; m_cv = 0; m_log = '0;

        // Reset state
        step("reset", 4'b0000, 16'h0000, 1'b0, 1'b1);
        check("reset_dir.reset_o", 32'(reset_o), 32'd0);

        // rst two cycles into a HOLD
        step("rh_pulse", 4'b0010, 16'h0000, 1'b0, 1'b0);
        step("rh_hold",  4'b0000, 16'h0000, 1'b0, 1'b0);
        step("rh_rst",   4'b0000, 16'h0000, 1'b0, 1'b1);
        check("rh_dir.kill_cnt", 32'(kill_cnt_o), 32'd0);
        check("rh_dir.reset_o",  32'(reset_o),    32'd0);
        step("rh_run", 4'b0000, RH, 1'b0, 1'b0);
        check("rh_dir.stays_run", 32'(reset_o), 32'd0);

        // Single pulse on source 2, handler fetched from cycle 10
        step("sp_pulse", 4'b0100, 16'h1234, 1'b0, 1'b0);
        check("sp_dir.reset_o", 32'(reset_o),    32'd1);
        check("sp_dir.cause",   32'(cause_o),    32'd2);
        check("sp_dir.kills",   32'(kill_cnt_o), 32'd1);
        for (int c = 1; c < 14; c++)
            step("sp_wait", 4'b0000, (c >= 10) ? RH : 16'h1234, 1'b0, 1'b0);
        check("sp_dir.released", 32'(reset_o), 32'd0);

        // Simultaneous sources -> lowest wins; later kill keeps first cause
        step("sm_rst", 4'b0000, 16'h0000, 1'b0, 1'b1);
        step("sm_pulse", 4'b1010, 16'h0000, 1'b0, 1'b0);
        check("sm_dir.cause", 32'(cause_o), 32'd1);
        for (int c = 0; c < 6; c++) step("sm_rel", 4'b0000, RH, 1'b0, 1'b0);
        step("sm_pulse2", 4'b0001, 16'h0000, 1'b0, 1'b0);
        check("sm_dir.cause2", 32'(cause_o),    32'd1);
        check("sm_dir.kills2", 32'(kill_cnt_o), 32'd2);
        for (int c = 0; c < 6; c++) step("sm_rel2", 4'b0000, RH, 1'b0, 1'b0);

        // Handler PC held throughout: minimum hold of MINH+1 cycles
        hi = 0;
        step("mh_pulse", 4'b0001, RH, 1'b0, 1'b0);
        if (reset_o) hi++;
        for (int c = 0; c < 10; c++) begin
            step("mh_hold", 4'b0000, RH, 1'b0, 1'b0);
            if (reset_o) hi++;
        end
        check("mh_dir.high_cycles", 32'(hi), 32'(MINH + 1));

        // Violation together with release in WAIT_RH -> full hold restarts
        step("wr_pulse", 4'b0100, 16'h0000, 1'b0, 1'b0);
        for (int c = 0; c < MINH; c++) step("wr_hold", 4'b0000, 16'h0000, 1'b0, 1'b0);
        step("wr_clash", 4'b0001, RH, 1'b0, 1'b0);
        check("wr_dir.still_high", 32'(reset_o), 32'd1);
        check("wr_dir.kills",      32'(kill_cnt_o), 32'd4);
        hi = 0;
        for (int c = 0; c < 10; c++) begin
            step("wr_rel", 4'b0000, RH, 1'b0, 1'b0);
            if (reset_o) hi++;
        end
        check("wr_dir.restart_len", 32'(hi), 32'(MINH));

        // Held level violation keeps reset asserted
        for (int c = 0; c < 20; c++) step("lv_hold", 4'b1000, RH, 1'b0, 1'b0);
        check("lv_dir.reset_o", 32'(reset_o), 32'd1);
        for (int c = 0; c < 6; c++) step("lv_rel", 4'b0000, RH, 1'b0, 1'b0);

        // 300 kill/release cycles -> saturation
        for (int k = 0; k < 300; k++) begin
            step("sat_pulse", 4'(1 << (k % NSRC)), RH, 1'b0, 1'b0);
            for (int c = 0; c < MINH + 1; c++) step("sat_rel", 4'b0000, RH, 1'b0, 1'b0);
        end
        check("sat_dir.kills", 32'(kill_cnt_o), 32'd255);

`ifdef VIOL_LOG_EN
        // Sticky log across two kills, then clear colliding with a set
        step("lg_rst", 4'b0000, 16'h0000, 1'b0, 1'b1);
        step("lg_k1", 4'b0001, 16'h0000, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) step("lg_r1", 4'b0000, RH, 1'b0, 1'b0);
        step("lg_k2", 4'b1000, 16'h0000, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) step("lg_r2", 4'b0000, RH, 1'b0, 1'b0);
        check("lg_dir.log", 32'(log_o), 32'h9);
        step("lg_clr", 4'b0010, 16'h0000, 1'b1, 1'b0);
        check("lg_dir.clr_set", 32'(log_o), 32'h2);
        for (int c = 0; c < 6; c++) step("lg_r3", 4'b0000, RH, 1'b0, 1'b0);
`endif

        // Randomized traffic against the model
        step("rnd_rst", 4'b0000, 16'h0000, 1'b0, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            logic [NSRC-1:0] v;
            logic [15:0]     p;
            v = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
            p = ($urandom_range(0, 2) == 0) ? RH : 16'($urandom);
            step("rnd", v, p, ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

endmodule
`default_nettype wire
